labfinalsoc_keys_edge_pio: RTL and testbench

- Avalon-MM slave input PIO. It is the read-side counterpart of the SoC's output LED PIO.
- Samples external push-button/switch lines and synchronizes them into the clock domain.
- Detects edges, latches them in a write-1-to-clear edge-capture register, and raises a maskable level interrupt to the Nios II.
- Sits on the system interconnect beside the LED PIO; it drives game controls (move/rotate/drop).

---
 rtl/labfinalsoc_keys_edge_pio.sv | 116 +++++++++++
 tb/tb_labfinalsoc_keys_edge_pio.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/labfinalsoc_keys_edge_pio.sv
// rtl/labfinalsoc_keys_edge_pio.sv - Avalon-MM input PIO with synchronizer, edge capture and maskable irq
// Optional debounce filter is compiled in with LABFINALSOC_KEYS_DEBOUNCE_EN.
module labfinalsoc_keys_edge_pio #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      read_mux;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^{writedata, 1'b0};
    assign sync_in      = sync_q[SYNC_STAGES-1];
    assign wr           = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

`ifdef LABFINALSOC_KEYS_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    logic [WIDTH-1:0][CW-1:0] deb_cnt;

    // Each bit only follows sync_in after it has disagreed for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt <= '0;
            data_in <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_in[i] == data_in[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt[i] <= '0;
                    data_in[i] <= sync_in[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_in <= '0;
        end else begin
            data_in <= sync_in;
        end
    end
`endif

    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            0:       edges = data_in & ~data_d;
            1:       edges = ~data_in & data_d;
            default: edges = data_in ^ data_d;
        endcase
    end

    assign clear_bits = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux[WIDTH-1:0] = data_in;
            2'd2:    read_mux[WIDTH-1:0] = irq_mask;
            2'd3:    read_mux[WIDTH-1:0] = edge_capture;
            default: read_mux = '0;
        endcase
    end

    // New edges are OR-ed in after the clear so a coincident edge keeps its bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_d       <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            data_d       <= data_in;
            edge_capture <= (edge_capture & ~clear_bits) | edges;
            readdata     <= read_mux;
            if (wr && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_labfinalsoc_keys_edge_pio.sv
// tb/tb_labfinalsoc_keys_edge_pio.sv - randomized self-checking bench for labfinalsoc_keys_edge_pio
// Reference model tracks input history and register contents at the transaction level.
module tb_labfinalsoc_keys_edge_pio;

    localparam int WIDTH     = 4;
    localparam int EDGE_TYPE = 0;
    localparam int S         = 2;
    localparam int DEB       = 8;
`ifdef LABFINALSOC_KEYS_DEBOUNCE_EN
    localparam int LAT = S + DEB;
`else
    localparam int LAT = S + 1;
`endif

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    labfinalsoc_keys_edge_pio #(
        .WIDTH(WIDTH), .EDGE_TYPE(EDGE_TYPE), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // q[j] holds the in_port value sampled j+1 clock edges ago.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_cap, m_mask, m_deb, m_deb_d;
    logic [WIDTH-1:0] din, dd, ev, clr, syn;
    logic [31:0]      m_rd;
    int               m_cnt[WIDTH];

    function automatic void model_reset();
        q.delete();
        repeat (S + 2) q.push_back('0);
        m_cap   = '0;
        m_mask  = '0;
        m_rd    = '0;
        m_deb   = '0;
        m_deb_d = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
`ifdef LABFINALSOC_KEYS_DEBOUNCE_EN
            din = m_deb;
            dd  = m_deb_d;
`else
            din = q[S];
            dd  = q[S+1];
`endif
            syn = q[S-1];
            if (EDGE_TYPE == 0)      ev = din & ~dd;
            else if (EDGE_TYPE == 1) ev = ~din & dd;
            else                     ev = din ^ dd;
            case (address)
                2'd0:    m_rd = 32'(din);
                2'd2:    m_rd = 32'(m_mask);
                2'd3:    m_rd = 32'(m_cap);
                default: m_rd = 32'd0;
            endcase
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[WIDTH-1:0];
            m_cap = (m_cap & ~clr) | ev;
            m_deb_d = m_deb;
            for (int i = 0; i < WIDTH; i++) begin
                if (syn[i] == m_deb[i]) m_cnt[i] = 0;
                else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB) begin
                        m_deb[i] = syn[i];
                        m_cnt[i] = 0;
                    end
                end
            end
            q.push_front(in_port);
            void'(q.pop_back());
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("readdata", readdata, m_rd);
            check("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] d;

    initial begin
        model_reset();
        reset_n = 1'b0; in_port = 4'hF; address = 2'd0; chipselect = 1'b0;
        write_n = 1'b1; writedata = 32'd0;
        idle(3);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        idle(LAT + 4);
        bus_read(2'd0, d); check("t1_data", d, 32'h0000000F);
        check("t1_irq", 32'(irq), 32'd0);
        bus_read(2'd3, d); check("t1_cap_powerup", d, 32'h0000000F);

        in_port = 4'h0; idle(LAT + 2);
        bus_write(2'd3, 32'hF); bus_write(2'd2, 32'h4);
        in_port = 4'h4; idle(LAT + 1);
        check("t2_irq_set", 32'(irq), 32'd1);
        bus_read(2'd3, d); check("t2_cap", d, 32'h4);
        bus_write(2'd3, 32'h4);
        check("t2_irq_clr", 32'(irq), 32'd0);

        bus_write(2'd2, 32'h0); in_port = 4'h0; idle(LAT + 2);
        bus_write(2'd3, 32'hF); in_port = 4'h1; idle(LAT + 2);
        check("t3_masked", 32'(irq), 32'd0);
        bus_read(2'd3, d); check("t3_cap", d, 32'h1);
        bus_write(2'd2, 32'h1); check("t3_unmask", 32'(irq), 32'd1);
        bus_write(2'd2, 32'h0); check("t3_remask", 32'(irq), 32'd0);

        bus_write(2'd3, 32'hF);
        in_port = 4'h3; idle(LAT);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, d); check("t4_collision", d, 32'h2);

        bus_write(2'd0, 32'hFFFFFFFF); bus_write(2'd1, 32'hFFFFFFFF);
        bus_read(2'd0, d); check("t5_data", d, 32'h3);
        bus_read(2'd1, d); check("t5_dir", d, 32'h0);
        bus_write(2'd2, 32'hF); check("t5_irq_pre", 32'(irq), 32'd1);
        in_port = 4'h0; idle(LAT + 2);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_readdata", readdata, 32'd0);
        check("t5_rst_irq", 32'(irq), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        idle(LAT + 2);
        bus_read(2'd2, d); check("t5_rst_mask", d, 32'h0);
        bus_read(2'd3, d); check("t5_rst_cap", d, 32'h0);

`ifdef LABFINALSOC_KEYS_DEBOUNCE_EN
        repeat (4) begin
            in_port = 4'h1; idle(3);
            in_port = 4'h0; idle(3);
        end
        idle(LAT + 2);
        bus_read(2'd3, d); check("t6_glitch", d, 32'h0);
        in_port = 4'h1; idle(LAT + 4);
        bus_read(2'd3, d); check("t6_stable", d, 32'h1);
        bus_write(2'd3, 32'h1); idle(10);
        bus_read(2'd3, d); check("t6_once", d, 32'h0);
`endif

        repeat (400) begin
            case ($urandom_range(0, 4))
                0: begin in_port = WIDTH'($urandom); idle($urandom_range(1, 14)); end
                1: bus_write(2'($urandom), $urandom);
                2: bus_read(2'($urandom), d);
                3: bus_write(2'd3, $urandom);
                default: bus_write(2'd2, $urandom);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
